// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory byte write port of the loader.
// A stream byte transfers on every rising clk edge where rx_valid && rx_ready; the source holds rx_data stable while rx_valid is high and unaccepted.
interface inst_mem_loader_if #(
  parameter int ADDR_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Streams a length-prefixed big-endian byte image into instruction memory while holding the core.
// Optional trailing checksum byte is enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int                MEM_BYTES = 1024,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  inst_mem_loader_if.slave        bus,
  output logic                    cpu_hold,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5
  } state_t;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t POST_PAYLOAD = CSUM;
`else
  localparam state_t POST_PAYLOAD = DONE;
`endif

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [15:0]       idx_q;
  logic              err_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              ready;
  logic              accept;
  logic              restart;
  logic [15:0]       len_next;
  logic              len_too_long;
  logic              last_byte;

  assign ready        = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                        (state_q == DATA)   || (state_q == CSUM);
  assign accept       = bus.rx_valid && ready;
  assign restart      = start && ((state_q == IDLE) || (state_q == DONE));
  assign len_next     = {len_hi_q, bus.rx_data};
  assign len_too_long = {16'd0, len_next} > 32'(MEM_BYTES);
  assign last_byte    = (idx_q == len_q - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = LEN_HI;
      LEN_HI: if (accept) state_d = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_too_long)         state_d = DONE;
          else if (len_next == '0)  state_d = POST_PAYLOAD;
          else                      state_d = DATA;
        end
      end
      DATA:   if (accept && last_byte) state_d = POST_PAYLOAD;
`ifdef INST_LOADER_CHECKSUM_EN
      CSUM:   if (accept) state_d = DONE;
`endif
      DONE:   if (start) state_d = LEN_HI;
      default: state_d = IDLE;
    endcase
  end

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  // The sum covers payload and checksum byte; a good image sums to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (restart) begin
      sum_q <= '0;
    end else if (accept && (state_q == DATA)) begin
      sum_q <= sum_q + bus.rx_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (restart) begin
        err_q <= 1'b0;
        idx_q <= '0;
      end
      if (accept) begin
        unique case (state_q)
          LEN_HI: len_hi_q <= bus.rx_data;
          LEN_LO: begin
            len_q <= len_next;
            idx_q <= '0;
            if (len_too_long) err_q <= 1'b1;
          end
          DATA: begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= BASE_ADDR + ADDR_W'(idx_q);
            mem_wdata_q <= bus.rx_data;
            idx_q       <= idx_q + 16'd1;
          end
`ifdef INST_LOADER_CHECKSUM_EN
          CSUM: if (8'(sum_q + bus.rx_data) != 8'h00) err_q <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready  = ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = ready;
  assign cpu_hold      = ready;
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: a byte-counting session model checked every cycle,
// plus literal per-session expectations on the resulting memory image.
`timescale 1ns/1ps
module tb_inst_mem_loader;
  localparam int          MEM_BYTES = 1024;
  localparam int          ADDR_W    = 32;
  localparam logic [31:0] BASE      = 32'd0;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic       cpu_hold, busy, done, err;
  logic [2:0] dbg_state;

  inst_mem_loader_if #(.ADDR_W(ADDR_W)) lif ();

  inst_mem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (lif),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // session model: counts accepted bytes and derives every output from the stream rules
  logic       m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int         m_cnt = 0, m_len = 0;
  logic [7:0] m_sum = 8'h00;
  logic       e_we = 1'b0;
  logic [31:0] e_addr = 32'd0;
  logic [7:0] e_data = 8'h00;
  logic [7:0] img [0:1023];
  int         wr_count = 0;

  function automatic void model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_cnt = 0; m_len = 0; m_sum = 8'h00; e_we = 1'b0;
  endfunction

  function automatic void finish_session();
    m_busy = 1'b0;
    m_done = 1'b1;
  endfunction

  function automatic void model_byte(input logic [7:0] d);
    int k;
    k = m_cnt;
    m_cnt++;
    if (k == 0) begin
      m_len = int'(d) * 256;
    end else if (k == 1) begin
      m_len = m_len + int'(d);
      if (m_len > MEM_BYTES) begin
        m_err = 1'b1;
        finish_session();
      end else if (m_len == 0 && !CS) begin
        finish_session();
      end
    end else if (k - 2 < m_len) begin
      e_we   = 1'b1;
      e_addr = BASE + 32'(k - 2);
      e_data = d;
      m_sum  = m_sum + d;
      if (k - 2 == m_len - 1 && !CS) finish_session();
    end else begin
      m_sum = m_sum + d;
      m_err = (m_sum != 8'h00);
      finish_session();
    end
  endfunction

  // scoreboard: check this cycle's outputs, then predict the effect of the coming edge
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    check("rx_ready", lif.rx_ready, m_busy);
    check("busy", busy, m_busy);
    check("cpu_hold", cpu_hold, m_busy);
    check("done", done, m_done);
    check("err", err, m_err);
    check("mem_we", lif.mem_we, e_we);
    if (e_we) begin
      check("mem_addr", lif.mem_addr, e_addr);
      check("mem_wdata", lif.mem_wdata, e_data);
    end
    if (lif.mem_we) begin
      img[lif.mem_addr[9:0]] = lif.mem_wdata;
      wr_count++;
    end
    e_we = 1'b0;
    if (rst_n) begin
      if (m_busy) begin
        if (lif.rx_valid) model_byte(lif.rx_data);
      end else if (start) begin
        m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0;
        m_cnt = 0; m_sum = 8'h00;
      end
    end
  end

  // driver tasks: each begins and ends 1 ns after a rising edge
  logic [7:0] pay [$];

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 8'h00;
    wr_count = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    lif.rx_valid = 1'b1;
    lif.rx_data  = b;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = lif.rx_ready;
      @(posedge clk); #1;
    end
    lif.rx_valid = 1'b0;
    if (!ok) fail_timeout("send_byte");
  endtask

  task automatic run_payload(input int gap, input bit use_fixed, input logic [7:0] fixed_csum);
    logic [7:0] s;
    s = 8'h00;
    send_byte(8'(pay.size() >> 8));
    send_byte(8'(pay.size()));
    foreach (pay[i]) begin
      send_byte(pay[i]);
      s = s + pay[i];
      for (int g = 0; g < gap; g++) begin
        start = (i == 5);  // mid-session start must be ignored
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    if (CS) send_byte(use_fixed ? fixed_csum : 8'(-s));
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      seen = done;
    end
    @(posedge clk); #1;
    if (!seen) fail_timeout("wait_done");
  endtask

  task automatic load_small_image();
    pay = {};
    pay.push_back(8'h00); pay.push_back(8'h10); pay.push_back(8'h03); pay.push_back(8'h13);
  endtask

  initial begin
    lif.rx_valid = 1'b0;
    lif.rx_data  = 8'h00;
    clear_img();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready", lif.rx_ready, 0);
    check("rst_mem_we", lif.mem_we, 0);
    check("rst_mem_addr", lif.mem_addr, 0);
    check("rst_mem_wdata", lif.mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // four-byte big-endian image
    clear_img();
    load_small_image();
    pulse_start();
    check("t1_busy_after_start", busy, 1);
    run_payload(0, 1'b0, 8'h00);
    wait_done();
    check("t1_done", done, 1);
    check("t1_err", err, 0);
    check("t1_cpu_hold", cpu_hold, 0);
    check("t1_writes", wr_count, 4);
    check("t1_img0", img[0], 8'h00);
    check("t1_img1", img[1], 8'h10);
    check("t1_img2", img[2], 8'h03);
    check("t1_img3", img[3], 8'h13);
    check("t1_img4", img[4], 8'h00);

    // 28 bytes with idle cycles between them
    clear_img();
    pay = {};
    for (int i = 0; i < 28; i++) pay.push_back(8'(i * 7 + 1));
    pulse_start();
    run_payload(1, 1'b0, 8'h00);
    wait_done();
    check("t2_writes", wr_count, 28);
    check("t2_img0", img[0], 8'h01);
    check("t2_img13", img[13], 8'h5c);
    check("t2_img27", img[27], 8'hbe);
    check("t2_img28", img[28], 8'h00);
    check("t2_err", err, 0);

    // over-length 1025
    clear_img();
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h01);
    lif.rx_valid = 1'b1;
    lif.rx_data  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_rx_ready_blocked", lif.rx_ready, 0);
      @(posedge clk); #1;
    end
    lif.rx_valid = 1'b0;
    wait_done();
    check("t3_err", err, 1);
    check("t3_done", done, 1);
    check("t3_writes", wr_count, 0);

    // zero length, good (or absent) checksum
    clear_img();
    pay = {};
    pulse_start();
    check("t4_err_cleared", err, 0);
    run_payload(0, 1'b0, 8'h00);
    wait_done();
    check("t4_done", done, 1);
    check("t4_err", err, 0);
    check("t4_writes", wr_count, 0);

`ifdef INST_LOADER_CHECKSUM_EN
    // zero length with checksum 01
    pulse_start();
    run_payload(0, 1'b1, 8'h01);
    wait_done();
    check("t4b_err", err, 1);
    check("t4b_done", done, 1);

    // payload intact, checksum 00 is wrong
    clear_img();
    load_small_image();
    pulse_start();
    run_payload(0, 1'b1, 8'h00);
    wait_done();
    check("t5_writes", wr_count, 4);
    check("t5_img3", img[3], 8'h13);
    check("t5_done", done, 1);
    check("t5_err", err, 1);
`endif

    // reset after two of four payload bytes
    clear_img();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'haa);
    send_byte(8'hbb);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mem_we", lif.mem_we, 0);
    check("t6_rst_cpu_hold", cpu_hold, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_img();
    load_small_image();
    pulse_start();
    run_payload(0, 1'b0, 8'h00);
    wait_done();
    check("t6_writes", wr_count, 4);
    check("t6_img0", img[0], 8'h00);
    check("t6_img1", img[1], 8'h10);
    check("t6_img2", img[2], 8'h03);
    check("t6_img3", img[3], 8'h13);
    check("t6_err", err, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
